afb_acc_regbank: RTL and testbench
==================================

# afb_acc_regbank

Parametrised AFB slave register bank serving as the register front-end of every AJIT accelerator. It accepts one AFB request at a time from the core, decodes it against a configurable base address, and performs 32-bit reads or byte-masked writes on NUM_REGS registers. It returns a response for every request, reads and writes alike, with an error flag. A hardware-side update port and a maskable interrupt let the accelerator datapath post status back to software.

## Interface
- NUM_REGS, 16, register count; power of two, 4..256.
- BASE_ADDR, 36'h0, AFB byte address of register 0; aligned to NUM_REGS*4.
- RO_MASK, {NUM_REGS{1'b0}} with bit 1 set, one bit per register; 1 = software read-only.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- afb_req_valid  in  1  AFB request pipe write_req.
- afb_req_ready  out  1  AFB request pipe write_ack.
- afb_req_data  in  74  [73] lock (ignored), [72] 1=read/0=write, [71:68] byte mask, [67:32] byte address, [31:0] write data.
- afb_resp_valid  out  1  AFB response pipe read_ack.
- afb_resp_ready  in  1  AFB response pipe read_req.
- afb_resp_data  out  33  [32] error, [31:0] read data (0 for writes and errors).
- hw_we  in  1  hardware register write strobe.
- hw_idx  in  $clog2(NUM_REGS)  hardware write target.
- hw_data  in  32  hardware write data.
- irq_set  in  1  one-cycle pulse; sets STATUS[0].
- regs_flat  out  NUM_REGS*32  current register contents; register i at [32i+31:32i].
- irq  out  1  CTRL[0] & STATUS[0].

## Operation
- Register 0 is CTRL: bit0 is irq_enable, and the other bits are general purpose. Register 1 is STATUS: bit0 is irq_pending and is write-1-to-clear from AFB. Registers 2 and up are general purpose.
- FSM states:
  - IDLE: afb_req_ready=1.
  - EXEC: decode and access.
  - RESP: afb_resp_valid=1.
- Transitions:
  - IDLE→EXEC when afb_req_valid&afb_req_ready; afb_req_data is captured into a request register.
  - EXEC→RESP unconditionally.
  - RESP→IDLE when afb_resp_ready.
- Decode: offset = addr − BASE_ADDR. An error is flagged, with no state change and response data 0, in any of these cases:
  - addr[1:0]≠0.
  - addr < BASE_ADDR.
  - offset ≥ NUM_REGS*4.
  - a write to a register whose RO_MASK bit is 1. Exception: STATUS W1C semantics still apply when STATUS is marked RO.
- Write: for each byte b with mask[b]=1, reg[idx][8b+7:8b] = data[8b+7:8b]. A mask of 0000 is a legal no-op write with error=0.
- Read: response data is the register value sampled in EXEC; error=0.
- Register update priority on the same register in the same cycle, highest first:
  1. reset.
  2. AFB write, per byte.
  3. hw_we write.
- For STATUS[0]: irq_set wins over an AFB W1C in the same cycle, so the bit stays 1.
- hw_we applies regardless of RO_MASK. hw_we with hw_idx=1 overwrites STATUS fully, including bit0, unless irq_set is asserted in the same cycle.

## Timing
- Reset values:
  - FSM: IDLE.
  - afb_req_ready: 0 during reset, 1 in the first cycle after reset.
  - afb_resp_valid: 0.
  - afb_resp_data: 0.
  - All registers: 0.
  - irq: 0.
- Latency: request accepted at edge N, afb_resp_valid high from N+2. Register write visible on regs_flat from N+2.
- afb_resp_valid and afb_resp_data stay stable until the handshake completes. Back-pressure is unbounded.
- Next acceptance is no earlier than the cycle after the response handshake, so throughput is at most 1 request per 3 cycles.
- irq is registered and rises one cycle after STATUS[0] and CTRL[0] are both 1.
- Reset asserted mid-transaction drops the request and any pending response; there is no partial write.

## Structure
- The package afb_acc_pkg holds:
  - request field constants (AFB_RW_BIT=72, AFB_MASK_HI/LO, AFB_ADDR_HI/LO=67/32).
  - response width 33.
  - register index constants CTRL_IDX=0, STATUS_IDX=1.
  - the FSM state enum.
- One sub-module, afb_req_decode, is combinational: it maps captured address/rw/mask to idx, err and wr_en. The register array and FSM live in the top.

## Test plan
- Reset, then read CTRL at BASE_ADDR → response 33'h0_00000000, arriving 2 cycles after acceptance.
- Write 32'hDEADBEEF with mask 1111 to BASE_ADDR+8, then write 32'h00000011 with mask 0001 to the same address, then read it → 32'hDEADBE11, error=0.
- Read BASE_ADDR+NUM_REGS*4, read BASE_ADDR+2, and write BASE_ADDR+4 (STATUS, RO) with mask 0010 → error=1 and data 0 for each, with registers unchanged.
- Write CTRL=1, pulse irq_set → irq=1. Write STATUS=1 → irq=0. Repeat with irq_set coincident with the W1C EXEC cycle → STATUS[0] stays 1 and irq stays 1.
- Issue a read and hold afb_resp_ready low for 10 cycles → afb_resp_valid and data stay stable and afb_req_ready=0 throughout; response completes when afb_resp_ready rises.
- hw_we to idx 3 in the same cycle as an AFB write to idx 3 with mask 0011 → low 16 bits come from AFB, high 16 bits from hw_data. Then assert reset mid-RESP → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/afb_acc_pkg.sv
// Shared constants and types for the AJIT accelerator AFB register front-end.
// Request/response field positions, well-known register indices and FSM states.
package afb_acc_pkg;

    localparam int AFB_REQ_W    = 74;
    localparam int AFB_LOCK_BIT = 73;
    localparam int AFB_RW_BIT   = 72;
    localparam int AFB_MASK_HI  = 71;
    localparam int AFB_MASK_LO  = 68;
    localparam int AFB_ADDR_HI  = 67;
    localparam int AFB_ADDR_LO  = 32;
    localparam int AFB_ADDR_W   = AFB_ADDR_HI - AFB_ADDR_LO + 1;
    localparam int AFB_RESP_W   = 33;
    localparam int AFB_ERR_BIT  = 32;

    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } afb_state_e;

endpackage

// File: rtl/afb_req_decode.sv
// Combinational decode of a captured AFB request against the register window.
// Produces the word index, the error flag and the write / STATUS-W1C enables.
module afb_req_decode
    import afb_acc_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [AFB_ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = {{(NUM_REGS-2){1'b0}}, 2'b10}
) (
    input  logic [AFB_ADDR_W-1:0]       i_addr,
    input  logic                        i_rd,
    input  logic                        i_mask_b0,
    output logic [$clog2(NUM_REGS)-1:0] o_idx,
    output logic                        o_err,
    output logic                        o_wr_en,
    output logic                        o_st_w1c
);

    localparam int IDXW = $clog2(NUM_REGS);
    localparam logic [AFB_ADDR_W-3:0] BASE_WORD = BASE_ADDR[AFB_ADDR_W-1:2];

    logic [AFB_ADDR_W-3:0] w_woff;
    logic                  w_addr_err;
    logic                  w_ro_err;

    // Base is word aligned, so comparing word addresses is exact once the
    // low two bits are known to be zero.
    assign w_woff     = i_addr[AFB_ADDR_W-1:2] - BASE_WORD;
    assign o_idx      = w_woff[IDXW-1:0];
    assign w_addr_err = (i_addr[1:0] != 2'b00)
                      | (i_addr[AFB_ADDR_W-1:2] < BASE_WORD)
                      | (w_woff[AFB_ADDR_W-3:IDXW] != '0);
    assign w_ro_err   = !i_rd & RO_MASK[o_idx];
    assign o_err      = w_addr_err | w_ro_err;
    assign o_wr_en    = !i_rd & !o_err;
    // STATUS[0] clear-on-write survives a read-only STATUS.
    assign o_st_w1c   = !i_rd & !w_addr_err & i_mask_b0
                      & (o_idx == IDXW'(STATUS_IDX));

endmodule

// File: rtl/afb_acc_regbank.sv
// AFB slave register bank: one request in flight, IDLE/EXEC/RESP handshake,
// byte-masked writes, hardware update port and a maskable status interrupt.
module afb_acc_regbank
    import afb_acc_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [AFB_ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = {{(NUM_REGS-2){1'b0}}, 2'b10}
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        afb_req_valid,
    output logic                        afb_req_ready,
    input  logic [AFB_REQ_W-1:0]        afb_req_data,
    output logic                        afb_resp_valid,
    input  logic                        afb_resp_ready,
    output logic [AFB_RESP_W-1:0]       afb_resp_data,
    input  logic                        hw_we,
    input  logic [$clog2(NUM_REGS)-1:0] hw_idx,
    input  logic [31:0]                 hw_data,
    input  logic                        irq_set,
    output logic [NUM_REGS*32-1:0]      regs_flat,
    output logic                        irq
);

    localparam int IDXW = $clog2(NUM_REGS);

    afb_state_e                   r_state, w_state_nxt;
    logic [AFB_RW_BIT:0]          r_req;
    logic [NUM_REGS-1:0][31:0]    r_regs, w_regs_nxt;
    logic [AFB_RESP_W-1:0]        r_resp;
    logic                         r_irq;
    logic                         w_accept, w_exec;
    logic                         w_rd;
    logic [3:0]                   w_mask;
    logic [31:0]                  w_wdata;
    logic [IDXW-1:0]              w_idx;
    logic                         w_err, w_wr_en, w_st_w1c;
    logic                         w_unused_lock;

    assign w_unused_lock = afb_req_data[AFB_LOCK_BIT];
    assign w_rd          = r_req[AFB_RW_BIT];
    assign w_mask        = r_req[AFB_MASK_HI:AFB_MASK_LO];
    assign w_wdata       = r_req[31:0];

    afb_req_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .RO_MASK   (RO_MASK)
    ) u_decode (
        .i_addr    (r_req[AFB_ADDR_HI:AFB_ADDR_LO]),
        .i_rd      (w_rd),
        .i_mask_b0 (w_mask[0]),
        .o_idx     (w_idx),
        .o_err     (w_err),
        .o_wr_en   (w_wr_en),
        .o_st_w1c  (w_st_w1c)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)       w_state_nxt = ST_EXEC;
            ST_EXEC:                     w_state_nxt = ST_RESP;
            ST_RESP: if (afb_resp_ready) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        afb_req_ready  = (r_state == ST_IDLE) & ~reset;
        afb_resp_valid = (r_state == ST_RESP);
        w_exec         = (r_state == ST_EXEC);
    end

    assign w_accept = afb_req_valid & afb_req_ready;

    always_ff @(posedge clk) begin
        if (reset)         r_req <= '0;
        else if (w_accept) r_req <= afb_req_data[AFB_RW_BIT:0];
    end

    always_ff @(posedge clk) begin
        if (reset)       r_resp <= '0;
        else if (w_exec) r_resp <= {w_err, (w_rd && !w_err) ? r_regs[w_idx] : 32'h0};
    end

    // Lowest priority first: hw port, then AFB bytes, then STATUS[0] rules.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_nxt[i] = r_regs[i];
            if (hw_we && hw_idx == IDXW'(i))
                w_regs_nxt[i] = hw_data;
            if (w_exec && w_wr_en && w_idx == IDXW'(i))
                for (int b = 0; b < 4; b++)
                    if (w_mask[b]) w_regs_nxt[i][8*b +: 8] = w_wdata[8*b +: 8];
        end
        if (w_exec && w_st_w1c)
            w_regs_nxt[STATUS_IDX][0] = r_regs[STATUS_IDX][0] & ~w_wdata[0];
        if (irq_set)
            w_regs_nxt[STATUS_IDX][0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_regs <= w_regs_nxt;
            r_irq  <= r_regs[CTRL_IDX][0] & r_regs[STATUS_IDX][0];
        end
    end

    assign regs_flat     = r_regs;
    assign afb_resp_data = r_resp;
    assign irq           = r_irq;

endmodule

// File: tb/tb_afb_acc_regbank.sv
// Directed plus randomized bench for afb_acc_regbank, checked against an
// address-arithmetic register model held in a plain array.
module tb_afb_acc_regbank;
    import afb_acc_pkg::*;

    localparam int          NREG = 16;
    localparam logic [35:0] BASE = 36'h4_0000_0100;
    localparam logic [15:0] RO   = 16'h0002;

    logic               clk, reset;
    logic               afb_req_valid, afb_req_ready;
    logic [73:0]        afb_req_data;
    logic               afb_resp_valid, afb_resp_ready;
    logic [32:0]        afb_resp_data;
    logic               hw_we;
    logic [3:0]         hw_idx;
    logic [31:0]        hw_data;
    logic               irq_set;
    logic [NREG*32-1:0] regs_flat;
    logic               irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m [NREG];
    bit          exec_irq, exec_hw;

    afb_acc_regbank #(.NUM_REGS(NREG), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .afb_req_valid(afb_req_valid), .afb_req_ready(afb_req_ready),
        .afb_req_data(afb_req_data),
        .afb_resp_valid(afb_resp_valid), .afb_resp_ready(afb_resp_ready),
        .afb_resp_data(afb_resp_data),
        .hw_we(hw_we), .hw_idx(hw_idx), .hw_data(hw_data),
        .irq_set(irq_set), .regs_flat(regs_flat), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word offset from base, bounds, RO and W1C rules.
    function automatic logic [32:0] model_afb(bit rd, logic [3:0] mask, logic [35:0] addr,
                                              logic [31:0] data);
        longint a, off;
        int     idx;
        logic   keep0;
        a   = longint'(addr);
        off = a - longint'(BASE);
        if ((a % 4) != 0 || off < 0 || off >= NREG * 4) return {1'b1, 32'h0};
        idx = int'(off / 4);
        if (rd) return {1'b0, m[idx]};
        if (idx == 1 && mask[0] && data[0]) m[1][0] = 1'b0;
        if (RO[idx]) return {1'b1, 32'h0};
        keep0 = m[1][0];
        for (int b = 0; b < 4; b++)
            if (mask[b]) m[idx][8*b +: 8] = data[8*b +: 8];
        if (idx == 1) m[1][0] = keep0;
        return 33'h0;
    endfunction

    // Leaves the bench at the RESP-cycle negedge; completes the handshake only
    // if afb_resp_ready is already high.
    task automatic afb_xact(input bit rd, input logic [3:0] mask, input logic [35:0] addr,
                            input logic [31:0] data, output logic [32:0] resp);
        @(negedge clk);
        check("req_ready_idle", afb_req_ready, 1);
        afb_req_valid = 1'b1;
        afb_req_data  = {1'b0, rd, mask, addr, data};
        @(posedge clk); #1;
        afb_req_valid = 1'b0;
        if (exec_irq) irq_set = 1'b1;
        if (exec_hw)  hw_we   = 1'b1;
        @(negedge clk);
        check("exec_no_resp_valid", afb_resp_valid, 0);
        @(posedge clk); #1;
        irq_set = 1'b0;
        hw_we   = 1'b0;
        @(negedge clk);
        check("resp_valid_lat2", afb_resp_valid, 1);
        resp = afb_resp_data;
        if (afb_resp_ready) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREG; i++)
            check($sformatf("%s_reg%0d", tag, i), regs_flat[32*i +: 32], m[i]);
        check({tag, "_irq"}, irq, m[0][0] & m[1][0]);
    endtask

    task automatic pulse_irq();
        @(negedge clk); irq_set = 1'b1;
        @(negedge clk); irq_set = 1'b0;
        m[1][0] = 1'b1;
    endtask

    task automatic pulse_hw(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk); hw_we = 1'b1; hw_idx = idx; hw_data = d;
        @(negedge clk); hw_we = 1'b0;
        m[idx] = d;
    endtask

    initial begin
        logic [32:0] resp, exp;
        logic [35:0] addr;
        bit          rd;
        logic [3:0]  mask;
        logic [31:0] data;
        int          r, idx;

        reset = 1'b1; afb_req_valid = 1'b0; afb_req_data = '0; afb_resp_ready = 1'b1;
        hw_we = 1'b0; hw_idx = '0; hw_data = '0; irq_set = 1'b0;
        exec_irq = 1'b0; exec_hw = 1'b0;
        for (int i = 0; i < NREG; i++) m[i] = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", afb_req_ready, 0);
        check("rst_resp_valid", afb_resp_valid, 0);
        check("rst_resp_data", afb_resp_data, 0);
        check("rst_irq", irq, 0);
        check("rst_regs_lo", regs_flat[63:0], 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", afb_req_ready, 1);

        afb_xact(1, 4'h0, BASE, 32'h0, resp);
        check("read_ctrl", resp, 33'h0_00000000);

        afb_xact(0, 4'hF, BASE + 8, 32'hDEADBEEF, resp);
        check("wr_full_resp", resp, model_afb(0, 4'hF, BASE + 8, 32'hDEADBEEF));
        afb_xact(0, 4'h1, BASE + 8, 32'h00000011, resp);
        check("wr_byte_resp", resp, model_afb(0, 4'h1, BASE + 8, 32'h00000011));
        afb_xact(1, 4'h0, BASE + 8, 32'h0, resp);
        check("rd_merged", resp, {1'b0, 32'hDEADBE11});

        afb_xact(1, 4'h0, BASE + NREG * 4, 32'h0, resp);
        check("err_oor", resp, {1'b1, 32'h0});
        afb_xact(1, 4'h0, BASE + 2, 32'h0, resp);
        check("err_misalign", resp, {1'b1, 32'h0});
        afb_xact(1, 4'h0, BASE - 4, 32'h0, resp);
        check("err_below", resp, {1'b1, 32'h0});
        afb_xact(0, 4'h2, BASE + 4, 32'hFFFFFFFF, resp);
        check("err_ro", resp, {1'b1, 32'h0});
        check_state("err_regs");

        afb_xact(0, 4'hF, BASE, 32'h1, resp);
        exp = model_afb(0, 4'hF, BASE, 32'h1);
        pulse_irq();
        check_state("irq_on");
        check("irq_rises", irq, 1);
        afb_xact(0, 4'h1, BASE + 4, 32'h1, resp);
        exp = model_afb(0, 4'h1, BASE + 4, 32'h1);
        check_state("irq_w1c");
        check("irq_cleared", irq, 0);
        pulse_irq();
        check_state("irq_again");
        exec_irq = 1'b1;
        afb_xact(0, 4'h1, BASE + 4, 32'h1, resp);
        exec_irq = 1'b0;
        exp = model_afb(0, 4'h1, BASE + 4, 32'h1);
        m[1][0] = 1'b1;
        check_state("irq_beats_w1c");
        check("irq_held", irq, 1);

        afb_resp_ready = 1'b0;
        afb_xact(1, 4'h0, BASE + 8, 32'h0, resp);
        check("bp_resp", resp, {1'b0, 32'hDEADBE11});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", afb_resp_valid, 1);
            check("bp_data", afb_resp_data, {1'b0, 32'hDEADBE11});
            check("bp_req_ready", afb_req_ready, 0);
        end
        afb_resp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", afb_resp_valid, 0);
        check("bp_done_ready", afb_req_ready, 1);

        hw_idx = 4'd3; hw_data = 32'hCAFEF00D; exec_hw = 1'b1;
        afb_xact(0, 4'h3, BASE + 12, 32'h12345678, resp);
        exec_hw = 1'b0;
        m[3] = 32'hCAFEF00D;
        check("collide_resp", resp, model_afb(0, 4'h3, BASE + 12, 32'h12345678));
        check_state("collide");
        check("collide_reg3", regs_flat[127:96], 32'hCAFE5678);

        afb_resp_ready = 1'b0;
        afb_xact(1, 4'h0, BASE + 12, 32'h0, resp);
        reset = 1'b1;
        for (int i = 0; i < NREG; i++) m[i] = '0;
        @(negedge clk);
        check("mid_rst_valid", afb_resp_valid, 0);
        check("mid_rst_data", afb_resp_data, 0);
        check("mid_rst_ready", afb_req_ready, 0);
        check("mid_rst_irq", irq, 0);
        for (int i = 0; i < NREG; i++)
            check($sformatf("mid_rst_reg%0d", i), regs_flat[32*i +: 32], 32'h0);
        reset = 1'b0;
        afb_resp_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_release", afb_req_ready, 1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            if (r == 0) pulse_irq();
            else if (r == 1) pulse_hw(4'($urandom_range(0, NREG - 1)), $urandom);
            idx  = $urandom_range(0, NREG - 1);
            rd   = 1'($urandom_range(0, 1));
            mask = 4'($urandom_range(0, 15));
            data = $urandom;
            r    = $urandom_range(0, 9);
            case (r)
                0:       addr = BASE + 36'(idx * 4 + $urandom_range(1, 3));
                1:       addr = BASE + 36'(NREG * 4 + idx * 4);
                2:       addr = BASE - 36'(4 * (1 + idx));
                default: addr = BASE + 36'(idx * 4);
            endcase
            afb_xact(rd, mask, addr, data, resp);
            check($sformatf("rand%0d_resp", n), resp, model_afb(rd, mask, addr, data));
            check_state($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
